tt_um_roy1707018_ro22: RTL and testbench



---
 rtl/tt_um_roy1707018_ro22.sv | 109 ++++++++++
 tb/tb_tt_um_roy1707018_ro22.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/tt_um_roy1707018_ro22.sv
// Ring-oscillator frequency counter: prescaled source edges counted over a 2^(8+W) clk window.
// Define RING_OSC_EN to build the on-chip ring oscillator; otherwise the internal source is tied low.
module tt_um_roy1707018_ro22 (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       ena,
   input  logic [7:0] ui_in,
   output logic [7:0] uo_out,
   input  logic [7:0] uio_in,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] ARM   = 2'd1;
   localparam logic [1:0] COUNT = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   logic [1:0]  state, state_next;
   logic [15:0] count, cyc, last;
   logic        div_clr, start_q, start_pulse;
   logic        sync1, sync2, sync_prev, rise;
   logic        ro_out, src, tap;
   logic [12:0] stage_clk;
   logic [11:0] div_q;
   logic        unused;

`ifdef RING_OSC_EN
   (* keep = "true", dont_touch = "true" *) logic [20:0] ro_n;
   assign ro_n[0] = ~(ui_in[0] & ena & ro_n[20]);
   for (genvar i = 1; i < 21; i++) begin : g_inv
      assign ro_n[i] = ~ro_n[i-1];
   end
   assign ro_out = ro_n[20];
`else
   assign ro_out = 1'b0;
`endif

   assign unused = &{1'b0, ui_in[0], uio_in[7:2]};

   assign src = ui_in[1] ? uio_in[0] : ro_out;

   // Ripple divider: each stage toggles on the falling edge of the previous one.
   assign stage_clk[0] = src;
   for (genvar i = 0; i < 12; i++) begin : g_div
      logic q;
      always_ff @(posedge stage_clk[i] or posedge div_clr) begin
         if (div_clr) q <= 1'b0;
         else         q <= ~q;
      end
      assign div_q[i]       = q;
      assign stage_clk[i+1] = ~q;
   end

   always_comb begin
      case (ui_in[6:5])
         2'd0:    tap = src;
         2'd1:    tap = div_q[3];
         2'd2:    tap = div_q[7];
         default: tap = div_q[11];
      endcase
   end

   assign rise        = sync2 & ~sync_prev;
   assign start_pulse = ui_in[7] & ~start_q;
   assign last        = (16'd1 << ({1'b0, ui_in[4:2]} + 4'd8)) - 16'd1;

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (start_pulse) state_next = ARM;
         ARM:     state_next = COUNT;
         COUNT:   if (cyc >= last) state_next = DONE;
         DONE:    if (start_pulse) state_next = ARM;
         default: state_next = IDLE;
      endcase
      if (!ena) state_next = IDLE;
   end

   always_ff @(posedge clk) begin
      if (rst_n) begin
         state     <= IDLE;
         count     <= '0;
         cyc       <= '0;
         start_q   <= 1'b0;
         sync1     <= 1'b0;
         sync2     <= 1'b0;
         sync_prev <= 1'b0;
         div_clr   <= 1'b1;
      end else begin
         state     <= state_next;
         start_q   <= ui_in[7];
         sync1     <= tap;
         sync2     <= sync1;
         sync_prev <= sync2;
         // Registered from next state so the divider is released exactly for ARM and COUNT.
         div_clr   <= (state_next == IDLE) || (state_next == DONE);
         if (!ena || state == ARM)
            count <= '0;
         else if (state == COUNT && rise && count != '1)
            count <= count + 16'd1;
         if (state == COUNT) cyc <= cyc + 16'd1;
         else                cyc <= '0;
      end
   end

   assign uo_out  = uio_in[1] ? count[15:8] : count[7:0];
   assign uio_out = {state == DONE, state == ARM || state == COUNT, sync2, tap, 4'b0000};
   assign uio_oe  = 8'hF0;
endmodule

// File: tb/tb_tt_um_roy1707018_ro22.sv
// Scoreboard bench for the ring-oscillator counter using the external test source.
module tb_tt_um_roy1707018_ro22;
   logic       clk = 1'b0;
   logic       rst_n, ena;
   logic [7:0] ui_in, uo_out, uio_in, uio_out, uio_oe;
   logic       ext_src = 1'b0;
   logic       byte_sel;
   int         tog_half = 0;
   int         ph = 0;
   int         checks = 0;
   int         errors = 0;
   int         exp_q[$];

   assign uio_in = {6'b000000, byte_sel, ext_src};

   tt_um_roy1707018_ro22 dut (
      .clk(clk), .rst_n(rst_n), .ena(ena), .ui_in(ui_in), .uo_out(uo_out),
      .uio_in(uio_in), .uio_out(uio_out), .uio_oe(uio_oe)
   );

   always #5 clk = ~clk;

   // External source toggles every tog_half clk cycles when enabled.
   always begin
      @(negedge clk);
      if (tog_half > 0) begin
         if (ph >= tog_half - 1) begin
            ext_src = ~ext_src;
            ph = 0;
         end else ph++;
      end
   end

   task automatic check(input string tag, input int obs, input int exp, input int tol = 0);
      checks++;
      if (obs < exp - tol || obs > exp + tol) begin
         errors++;
         $display("FAIL %s: got %0d want %0d (tol %0d)", tag, obs, exp, tol);
      end
   endtask

   task automatic run_meas(input string tag, input logic sel, input logic [2:0] w,
                           input logic [1:0] p, input int exp_cnt, input int tol,
                           input bit mid_start);
      int bc;
      bit got;
      int exp;
      logic [7:0] lo, hi;
      ui_in[1]   = sel;
      ui_in[4:2] = w;
      ui_in[6:5] = p;
      @(negedge clk);
      ui_in[7] = 1'b1;
      exp_q.push_back(exp_cnt);
      @(negedge clk);
      ui_in[7] = 1'b0;
      bc = 0;
      got = 0;
      for (int c = 0; c < 40000; c++) begin
         if (uio_out[7]) begin
            got = 1;
            break;
         end
         if (uio_out[6]) bc++;
         if (mid_start && c == 50) ui_in[7] = 1'b1;
         if (mid_start && c == 51) ui_in[7] = 1'b0;
         @(negedge clk);
      end
      check({tag, "_done"}, int'(got), 1);
      check({tag, "_busy"}, bc, (1 << (8 + int'(w))) + 1);
      check({tag, "_sb"}, exp_q.size(), 1);
      if (exp_q.size() > 0) begin
         exp = exp_q.pop_front();
         byte_sel = 1'b0;
         #1 lo = uo_out;
         byte_sel = 1'b1;
         #1 hi = uo_out;
         byte_sel = 1'b0;
         check({tag, "_cnt"}, int'({hi, lo}), exp, tol);
      end
   endtask

   initial begin
      bit seen;
      rst_n = 1'b1;
      ena = 1'b1;
      ui_in = '0;
      byte_sel = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_uo", uo_out, 0);
      check("rst_uio", uio_out, 0);
      check("rst_oe", uio_oe, 8'hF0);
      rst_n = 1'b0;
      @(negedge clk);

      // Internal source with no oscillator built counts nothing.
      run_meas("int", 1'b0, 3'd0, 2'd0, 0, 0, 0);
      check("done_flag", uio_out[7], 1);

      tog_half = 4;
      run_meas("ext_w0", 1'b1, 3'd0, 2'd0, 32, 1, 0);
      run_meas("ext_p1w4", 1'b1, 3'd4, 2'd1, 32, 1, 0);
      byte_sel = 1'b1;
      #1 check("hi_byte", uo_out, 0);
      byte_sel = 1'b0;

      tog_half = 2;
      run_meas("ext_w7", 1'b1, 3'd7, 2'd0, 8192, 1, 0);

      tog_half = 4;
      run_meas("mid_start", 1'b1, 3'd1, 2'd0, 64, 1, 1);

      // Reset during COUNT aborts without a done indication.
      ui_in[4:2] = 3'd2;
      @(negedge clk);
      ui_in[7] = 1'b1;
      @(negedge clk);
      ui_in[7] = 1'b0;
      repeat (100) @(negedge clk);
      check("mid_busy", uio_out[6], 1);
      rst_n = 1'b1;
      @(negedge clk);
      rst_n = 1'b0;
      check("abort_busy", uio_out[6], 0);
      check("abort_done", uio_out[7], 0);
      check("abort_cnt", uo_out, 0);
      seen = 0;
      repeat (1200) begin
         @(negedge clk);
         if (uio_out[7]) seen = 1;
      end
      check("abort_no_done", int'(seen), 0);

      // Dropping ena mid-measurement returns to IDLE with the count cleared.
      ui_in[4:2] = 3'd0;
      @(negedge clk);
      ui_in[7] = 1'b1;
      @(negedge clk);
      ui_in[7] = 1'b0;
      repeat (100) @(negedge clk);
      check("ena_pre_cnt", uo_out, 12, 1);
      ena = 1'b0;
      @(negedge clk);
      ena = 1'b1;
      check("ena_busy", uio_out[6], 0);
      check("ena_cnt", uo_out, 0);
      seen = 0;
      repeat (400) begin
         @(negedge clk);
         if (uio_out[7]) seen = 1;
      end
      check("ena_no_done", int'(seen), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
